// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// mandelbrot_pkg : shared fixed-point, screen and state definitions
// Revision       : 1.0
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

    localparam int FX_W  = 27;
    localparam int FRAC  = 23;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/coord_clamp.sv
// ============================================================================
// coord_clamp : combinational signed clamp of a 32-bit value to 0..LIMIT-1
// Revision    : 1.0
// ============================================================================
`default_nettype none

module coord_clamp #(
    parameter int LIMIT = 640,
    parameter int WIDTH = 10
) (
    input  logic [31:0]      value,
    output logic [WIDTH-1:0] clamped
);

    localparam logic signed [31:0] C_LIMIT = 32'(LIMIT);
    localparam logic [WIDTH-1:0]   C_MAX   = WIDTH'(LIMIT - 1);

    always_comb begin
        clamped = value[WIDTH-1:0];
        if ($signed(value) < 0) begin
            clamped = '0;
        end else if ($signed(value) >= C_LIMIT) begin
            clamped = C_MAX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mouse_view_ctrl.sv
// ============================================================================
// mouse_view_ctrl : turns mouse PIO positions into Mandelbrot point requests
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mouse_view_ctrl #(
    parameter int H_RES = mandelbrot_pkg::H_RES,
    parameter int V_RES = mandelbrot_pkg::V_RES,
    parameter int FX_W  = mandelbrot_pkg::FX_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     mouse_x,
    input  logic [31:0]     mouse_y,
    input  logic [FX_W-1:0] re_min,
    input  logic [FX_W-1:0] im_max,
    input  logic [FX_W-1:0] step,
    output logic            pt_valid,
    input  logic            pt_ready,
    output logic [FX_W-1:0] pt_re,
    output logic [FX_W-1:0] pt_im,
    output logic [9:0]      cursor_x,
    output logic [8:0]      cursor_y
);

    import mandelbrot_pkg::*;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_latch;
    logic            w_calc;
    logic            w_accept;

    logic [31:0]     r_last_x;
    logic [31:0]     r_last_y;
    logic [31:0]     r_work_x;
    logic [31:0]     r_work_y;

    logic            r_pt_valid;
    logic [FX_W-1:0] r_pt_re;
    logic [FX_W-1:0] r_pt_im;
    logic [9:0]      r_cursor_x;
    logic [8:0]      r_cursor_y;

    logic [9:0]      w_cx;
    logic [8:0]      w_cy;
    logic [FX_W-1:0] w_cx_fx;
    logic [FX_W-1:0] w_cy_fx;
    logic [FX_W-1:0] w_re;
    logic [FX_W-1:0] w_im;

    coord_clamp #(.LIMIT(H_RES), .WIDTH(10)) u_clamp_x (
        .value   (r_work_x),
        .clamped (w_cx)
    );

    coord_clamp #(.LIMIT(V_RES), .WIDTH(9)) u_clamp_y (
        .value   (r_work_y),
        .clamped (w_cy)
    );

    // Modular FX_W-bit arithmetic yields exactly the low FX_W bits of the
    // full-precision signed result, so wrap behaviour matches a wide datapath.
    assign w_cx_fx = FX_W'(w_cx);
    assign w_cy_fx = FX_W'(w_cy);
    assign w_re    = re_min + w_cx_fx * step;
    assign w_im    = im_max - w_cy_fx * step;

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_calc       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if ({mouse_x, mouse_y} != {r_last_x, r_last_y}) begin
                    w_latch      = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_calc       = 1'b1;
                w_state_next = SEND;
            end
            SEND: begin
                if (r_pt_valid && pt_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_work_x   <= '0;
            r_work_y   <= '0;
            r_pt_valid <= 1'b0;
            r_pt_re    <= '0;
            r_pt_im    <= '0;
            r_cursor_x <= '0;
            r_cursor_y <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_last_x <= mouse_x;
                r_last_y <= mouse_y;
                r_work_x <= mouse_x;
                r_work_y <= mouse_y;
            end
            if (w_calc) begin
                r_cursor_x <= w_cx;
                r_cursor_y <= w_cy;
                r_pt_re    <= w_re;
                r_pt_im    <= w_im;
                r_pt_valid <= 1'b1;
            end
            if (w_accept) begin
                r_pt_valid <= 1'b0;
            end
        end
    end

    assign pt_valid = r_pt_valid;
    assign pt_re    = r_pt_re;
    assign pt_im    = r_pt_im;
    assign cursor_x = r_cursor_x;
    assign cursor_y = r_cursor_y;

endmodule

`default_nettype wire

// File: tb/tb_mouse_view_ctrl.sv
// ============================================================================
// tb_mouse_view_ctrl : scoreboard bench for mouse_view_ctrl
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mouse_view_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mouse_x;
    logic [31:0] mouse_y;
    logic [26:0] re_min;
    logic [26:0] im_max;
    logic [26:0] step;
    logic        pt_valid;
    logic        pt_ready;
    logic [26:0] pt_re;
    logic [26:0] pt_im;
    logic [9:0]  cursor_x;
    logic [8:0]  cursor_y;

    always #5 clk = ~clk;

    mouse_view_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mouse_x  (mouse_x),
        .mouse_y  (mouse_y),
        .re_min   (re_min),
        .im_max   (im_max),
        .step     (step),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_re    (pt_re),
        .pt_im    (pt_im),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    typedef struct {
        logic [26:0] re;
        logic [26:0] im;
        logic [9:0]  cx;
        logic [8:0]  cy;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   active = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input int re, input int im, input int cx, input int cy);
        exp_t e;
        e.re = 27'(re);
        e.im = 27'(im);
        e.cx = 10'(cx);
        e.cy = 9'(cy);
        return e;
    endfunction

    // Monitor: pops one expectation per presented request and checks it
    // every cycle until the handshake, which also covers output stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0;
        end else if (pt_valid) begin
            if (!active) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid got pt_valid=1 want no request at %0t", $time);
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                end
            end
            if (active) begin
                chk("pt_re",    32'(pt_re),    32'(cur.re));
                chk("pt_im",    32'(pt_im),    32'(cur.im));
                chk("cursor_x", 32'(cursor_x), 32'(cur.cx));
                chk("cursor_y", 32'(cursor_y), 32'(cur.cy));
                if (pt_ready) active = 1'b0;
            end
        end
    end

    task automatic request(input int x, input int y, input exp_t e);
        sb.push_back(e);
        @(posedge clk); #1;
        mouse_x = 32'(x);
        mouse_y = 32'(y);
        @(negedge clk); chk("lat_k",  32'(pt_valid), 32'd0);
        @(negedge clk); chk("lat_k1", 32'(pt_valid), 32'd0);
        @(negedge clk); chk("lat_k2", 32'(pt_valid), 32'd1);
    endtask

    task automatic wait_drain(input int n);
        bit done = 1'b0;
        for (int i = 0; i < n && !done; i++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !active) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic expect_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_valid", 32'(pt_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_n  = 1'b0;
        mouse_x  = '0;
        mouse_y  = '0;
        pt_ready = 1'b1;
        re_min   = 27'(-16777216);
        im_max   = 27'(8388608);
        step     = 27'(32768);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        chk("rst_valid",    32'(pt_valid), 32'd0);
        chk("rst_re",       32'(pt_re),    32'd0);
        chk("rst_im",       32'(pt_im),    32'd0);
        expect_idle(20);
        chk("rst_cursor_x", 32'(cursor_x), 32'd0);
        chk("rst_cursor_y", 32'(cursor_y), 32'd0);

        // Centre of screen.
        request(320, 240, mk(-6291456, 524288, 320, 240));
        wait_drain(20);

        // Both coordinates out of range.
        request(-5, 1000, mk(-16777216, -7307264, 0, 479));
        wait_drain(20);

        // Coalescing while the dispatcher stalls.
        pt_ready = 1'b0;
        sb.push_back(mk(-16449536, -7307264, 10, 479));
        sb.push_back(mk(-15794176, -7307264, 30, 479));
        @(posedge clk); #1 mouse_x = 32'd10;
        repeat (3) @(posedge clk);
        #1 mouse_x = 32'd20;
        repeat (3) @(posedge clk);
        #1 mouse_x = 32'd30;
        repeat (4) @(posedge clk);
        #1 pt_ready = 1'b1;
        wait_drain(20);
        chk("coalesce_cursor_x", 32'(cursor_x), 32'd30);

        // Same-value rewrite produces nothing.
        request(320, 1000, mk(-6291456, -7307264, 320, 479));
        wait_drain(20);
        @(posedge clk); #1 mouse_x = 32'd320;
        expect_idle(10);

        // Reset while a request is pending.
        pt_ready = 1'b0;
        sb.push_back(mk(-13500416, -7307264, 100, 479));
        @(posedge clk); #1 mouse_x = 32'd100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (pt_valid) seen = 1'b1;
        end
        chk("send_reached", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_async_valid",  32'(pt_valid), 32'd0);
        chk("rst_async_cursor", 32'(cursor_x), 32'd0);
        mouse_x  = '0;
        mouse_y  = '0;
        pt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        expect_idle(10);
        chk("rst_sb_empty", 32'(sb.size()), 32'd0);

        request(5, 7, mk(-16613376, 8159232, 5, 7));
        wait_drain(20);
        expect_idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mouse_view_ctrl.md
Name: mouse_view_ctrl

Overview:
- Consumes the raw 32-bit mouse X/Y coordinates driven by the HPS-written PIO output ports.
- Detects a new mouse position and clamps it to the visible screen.
- Converts the position into a Mandelbrot complex-plane point in 4.23 fixed point.
- Hands the point to the Mandelbrot iterator dispatcher over a valid/ready handshake. It also outputs clamped pixel coordinates for the VGA cursor overlay.

Parameters:
- H_RES, 640, visible width in pixels; the clamped X range is 0..H_RES-1.
- V_RES, 480, visible height in pixels; the clamped Y range is 0..V_RES-1.
- FX_W, 27, signed fixed-point width of complex coordinates.
- FRAC, 23, fractional bits of the fixed-point format (4.23).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mouse_x  in  32  PIO out_port value, interpreted as signed
- mouse_y  in  32  PIO out_port value, interpreted as signed
- re_min  in  FX_W  signed real coordinate of pixel column 0
- im_max  in  FX_W  signed imaginary coordinate of pixel row 0
- step  in  FX_W  signed per-pixel increment (positive)
- pt_valid  out  1  point request valid
- pt_ready  in  1  dispatcher accepts the point
- pt_re  out  FX_W  real part of the requested point
- pt_im  out  FX_W  imaginary part of the requested point
- cursor_x  out  10  clamped X for the overlay
- cursor_y  out  9  clamped Y for the overlay

Behaviour:
- Clock and reset: single clock. reset_n is asynchronous, active-low.
- Reset values: all outputs 0; last_x = 0, last_y = 0; state IDLE. Because the PIO resets to 0, there is no spurious request out of reset.
- IDLE:
  - If {mouse_x, mouse_y} != {last_x, last_y}: latch both inputs into last_x/last_y and into working registers, then go to CALC.
  - Otherwise stay in IDLE.
- CALC: a single cycle.
  - Clamp each coordinate: a negative value becomes 0; a value ≥ RES becomes RES-1.
  - cursor_x and cursor_y update with the clamped values at the end of CALC.
  - pt_re = re_min + cx*step, and pt_im = im_max - cy*step. Compute in full precision (signed, FX_W+11 bits), then truncate to the low FX_W bits; two's-complement wrap, no saturation.
  - re_min, im_max and step are sampled during CALC only.
  - Register the results, set pt_valid = 1 and go to SEND.
- Latency: an input change visible in cycle k gives pt_valid = 1 in cycle k+2.
- SEND:
  - Hold pt_valid, pt_re and pt_im stable until pt_valid && pt_ready is sampled at a clock edge.
  - At that edge, deassert pt_valid and return to IDLE.
  - pt_ready while pt_valid = 0 is ignored.
- Coalescing: input changes during CALC or SEND are not latched. IDLE re-compares the inputs after the handshake, so only the latest position is requested and intermediate positions are dropped.
- Same-value write: no request is generated; the comparison is against the last latched value.
- Reset mid-operation: pt_valid drops asynchronously, any in-flight request is discarded, and the state returns to IDLE.
- One outstanding request at a time. Back-to-back requests are possible: handshake at edge n, back in IDLE, CALC, new valid at n+2.

Decomposition:
- Shared package mandelbrot_pkg:
  - FX_W/FRAC constants
  - fixed-point typedef fx_t
  - H_RES/V_RES
  - state enum {IDLE, CALC, SEND}
- One natural sub-module: coord_clamp, a combinational signed clamp of a 32-bit value to 0..LIMIT-1, instantiated for X and Y.

Test Plan:
- Reset, then both inputs held at 0 for 20 cycles → pt_valid stays 0; cursor = (0,0).
- re_min = -16777216, im_max = 8388608, step = 32768; set x = 320, y = 240 → pt_valid two cycles later; pt_re = -6291456, pt_im = 524288; cursor = (320,240).
- Same set-up with x = -5, y = 1000 → cursor = (0,479); pt_re = -16777216, pt_im = 8388608 - 479*32768 = -7307264.
- Hold pt_ready = 0 for 10 cycles while x steps 10→20→30 → outputs stay at the first point; after pt_ready = 1 the next request carries x = 30 only.
- Rewrite x = 320 with the same value → no new pt_valid.
- Assert reset_n = 0 while in SEND → pt_valid = 0 immediately; after release, no request until the inputs differ from 0.
